// File: rtl/csa_acc_seq.sv
`default_nettype none
// ============================================================================
//  Module   : csa_acc_seq
//  Purpose  : Sequential partial-product accumulator. One 3:2 compressor row
//             folds each accepted partial product into a redundant sum/carry
//             register pair; a single carry-propagate add resolves the result,
//             which is offered on a valid/ready port.
//  Revision : 1.0  initial release
// ============================================================================
module csa_acc_seq #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] num_pp,
  input  logic             pp_valid,
  input  logic [WIDTH-1:0] pp_data,
  output logic             pp_ready,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ACCUM   = 2'd1,
    S_RESOLVE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] c_CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);

  state_t             r_state;
  state_t             w_next;
  logic [WIDTH-1:0]   r_sum;
  // Only the low WIDTH-1 carry bits are kept: the MSB is shifted out of the
  // word on every use, which is what makes the sum wrap modulo 2^WIDTH.
  logic [WIDTH-2:0]   r_carry;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_res;

  logic [WIDTH-1:0]   w_op2;
  logic [WIDTH-1:0]   w_s;
  logic [WIDTH-2:0]   w_c;
  logic [WIDTH-1:0]   w_final;
  logic               w_accept;
  logic               w_load;
  logic               w_pp_ready;
  logic               w_res_valid;
  logic               w_busy;

  // Compressor row: op1 = sum, op2 = carry shifted left, op3 = incoming PP
  assign w_op2   = {r_carry, 1'b0};
  assign w_s     = r_sum ^ w_op2 ^ pp_data;
  assign w_c     = (r_sum[WIDTH-2:0] & w_op2[WIDTH-2:0])
                 | (r_sum[WIDTH-2:0] & pp_data[WIDTH-2:0])
                 | (w_op2[WIDTH-2:0] & pp_data[WIDTH-2:0]);
  assign w_final = r_sum + w_op2;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode and handshake outputs
  always_comb begin
    w_next      = r_state;
    w_pp_ready  = 1'b0;
    w_res_valid = 1'b0;
    w_busy      = 1'b1;
    w_accept    = 1'b0;
    w_load      = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_busy = 1'b0;
        if (start) begin
          w_load = 1'b1;
          w_next = (num_pp != c_CNT_ZERO) ? S_ACCUM : S_RESOLVE;
        end
      end
      S_ACCUM: begin
        w_pp_ready = 1'b1;
        if (pp_valid) begin
          w_accept = 1'b1;
          if (r_cnt == c_CNT_ONE) begin
            w_next = S_RESOLVE;
          end
        end
      end
      S_RESOLVE: begin
        w_next = S_DONE;
      end
      S_DONE: begin
        w_res_valid = 1'b1;
        if (res_ready) begin
          w_next = S_IDLE;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Datapath: clear/load on start, fold on each beat, resolve once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sum   <= '0;
      r_carry <= '0;
      r_cnt   <= '0;
      r_res   <= '0;
    end else begin
      if (w_load) begin
        r_sum   <= '0;
        r_carry <= '0;
        r_cnt   <= num_pp;
      end else if (w_accept) begin
        r_sum   <= w_s;
        r_carry <= w_c;
        r_cnt   <= r_cnt - c_CNT_ONE;
      end
      if (r_state == S_RESOLVE) begin
        r_res <= w_final;
      end
    end
  end

  assign pp_ready  = w_pp_ready;
  assign res_valid = w_res_valid;
  assign res_data  = r_res;
  assign busy      = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_csa_acc_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_csa_acc_seq
//  Purpose  : Self-checking bench for csa_acc_seq; expected results are the
//             plain modulo-2^16 sum of the partial products of each operation.
//  Revision : 1.0  initial release
// ============================================================================
module tb_csa_acc_seq;

  localparam int WIDTH = 16;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [CNT_W-1:0] num_pp;
  logic             pp_valid;
  logic [WIDTH-1:0] pp_data;
  logic             pp_ready;
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] res_data;
  logic             busy;

  int n_chk = 0;
  int n_err = 0;
  logic [WIDTH-1:0] pp_q [0:15];

  csa_acc_seq #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .num_pp    (num_pp),
    .pp_valid  (pp_valid),
    .pp_data   (pp_data),
    .pp_ready  (pp_ready),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Single comparison point for the whole bench
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete operation using pp_q[0..n-1].
  // gap  : idle cycles before each beat (-1 = random)
  // hold : cycles res_ready stays low in DONE (-1 = random)
  // noise: toggle start/res_ready/pp_data where they must be ignored
  task automatic run_op(input int n, input int gap, input int hold, input bit noise);
    int unsigned acc;
    logic [WIDTH-1:0] exp;
    int g;
    int w;
    acc = 0;
    for (int k = 0; k < n; k++) acc += pp_q[k];
    exp = WIDTH'(acc);

    check_eq("idle_busy", busy, 0);
    start  = 1'b1;
    num_pp = CNT_W'(n);
    tick();
    start  = 1'b0;
    num_pp = CNT_W'($urandom);
    if (n == 0) check_eq("zero_pp_ready", pp_ready, 0);

    for (int k = 0; k < n; k++) begin
      g = (gap >= 0) ? gap : (($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0);
      pp_valid = 1'b0;
      for (int j = 0; j < g; j++) begin
        if (noise) begin
          start     = 1'($urandom);
          num_pp    = CNT_W'($urandom);
          res_ready = 1'($urandom);
          pp_data   = WIDTH'($urandom);
        end
        tick();
        check_eq("gap_busy", busy, 1);
      end
      start    = 1'b0;
      pp_valid = 1'b1;
      pp_data  = pp_q[k];
      check_eq("accum_pp_ready", pp_ready, 1);
      check_eq("accum_res_valid", res_valid, 0);
      tick();
    end

    // RESOLVE cycle: nothing accepted, result not yet valid
    pp_valid  = noise ? 1'($urandom) : 1'b0;
    pp_data   = WIDTH'($urandom);
    res_ready = noise ? 1'($urandom) : 1'b0;
    check_eq("resolve_pp_ready", pp_ready, 0);
    check_eq("resolve_res_valid", res_valid, 0);
    check_eq("resolve_busy", busy, 1);
    tick();
    pp_valid = 1'b0;

    check_eq("done_res_valid", res_valid, 1);
    check_eq("done_res_data", res_data, exp);
    w = (hold >= 0) ? hold : $urandom_range(0, 4);
    res_ready = 1'b0;
    for (int j = 0; j < w; j++) begin
      start = noise ? 1'($urandom) : 1'b0;
      tick();
      check_eq("hold_res_valid", res_valid, 1);
      check_eq("hold_res_data", res_data, exp);
      check_eq("hold_busy", busy, 1);
    end
    start     = 1'b0;
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check_eq("exit_res_valid", res_valid, 0);
    check_eq("exit_busy", busy, 0);
    check_eq("exit_res_data", res_data, exp);
  endtask

  // Watchdog: the bench must always end by itself
  initial begin
    #10ms;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", n_err + 1, n_chk + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    num_pp    = '0;
    pp_valid  = 1'b0;
    pp_data   = '0;
    res_ready = 1'b0;
    repeat (3) tick();
    check_eq("rst_pp_ready", pp_ready, 0);
    check_eq("rst_res_valid", res_valid, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_res_data", res_data, 0);
    rst_n = 1'b1;
    tick();

    // Small sum, no stalls
    pp_q[0] = 16'h0003; pp_q[1] = 16'h0005; pp_q[2] = 16'h0007;
    run_op(3, 0, 0, 1'b0);
    check_eq("t1_value", res_data, 16'h000F);

    // Wrap-around cases
    pp_q[0] = 16'hFFFF; pp_q[1] = 16'h0002;
    run_op(2, 0, 0, 1'b0);
    check_eq("t2_wrap", res_data, 16'h0001);
    for (int k = 0; k < 4; k++) pp_q[k] = 16'h8000;
    run_op(4, 0, 1, 1'b0);
    check_eq("t2_msb", res_data, 16'h0000);

    // pp_valid while idle is ignored
    pp_valid = 1'b1;
    pp_data  = 16'hBEEF;
    tick();
    check_eq("idle_pp_ready", pp_ready, 0);
    check_eq("idle_busy2", busy, 0);
    pp_valid = 1'b0;

    // num_pp = 0 skips accumulation, then a single PP
    pp_q[0] = 16'h1234;
    run_op(1, 0, 0, 1'b0);
    check_eq("t3_single", res_data, 16'h1234);
    run_op(0, 0, 0, 1'b1);
    check_eq("t3_zero", res_data, 16'h0000);

    // Gapped beats, long result stall, stray start pulses
    pp_q[0] = 16'h4321; pp_q[1] = 16'h1111;
    run_op(2, 3, 5, 1'b1);
    check_eq("t4_value", res_data, 16'h5432);

    // Async reset mid-accumulation discards the operation
    start  = 1'b1;
    num_pp = 4'd3;
    tick();
    start    = 1'b0;
    pp_valid = 1'b1;
    pp_data  = 16'h0100;
    tick();
    pp_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    check_eq("abort_pp_ready", pp_ready, 0);
    check_eq("abort_busy", busy, 0);
    check_eq("abort_res_valid", res_valid, 0);
    check_eq("abort_res_data", res_data, 0);
    tick();
    rst_n = 1'b1;
    tick();
    check_eq("abort_idle", busy, 0);
    pp_q[0] = 16'h0010; pp_q[1] = 16'h0010;
    run_op(2, 0, 0, 1'b0);
    check_eq("t5_clean", res_data, 16'h0020);

    // Randomised operations against the arithmetic reference
    for (int op = 0; op < 1000; op++) begin
      int n;
      n = $urandom_range(0, 15);
      for (int k = 0; k < 16; k++) pp_q[k] = WIDTH'($urandom);
      run_op(n, -1, -1, 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
